// File: rtl/mem_2port_be.sv
// Single-clock true dual-port RAM with per-lane byte enables, selectable read-during-write,
// optional output register, same-address collision flag and a post-reset clear sweep.
module mem_2port_be #(
  parameter int          N         = 16,
  parameter int          L         = 2,
  parameter int          BW        = 8,
  parameter int          RDW_MODE  = 0,
  parameter int          OUT_REG   = 0,
  parameter int          INIT_EN   = 1,
  parameter logic [N-1:0] INIT_VAL = '0,
  parameter string       INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  output logic              init_busy,
  input  logic [L-1:0]      addr_a,
  input  logic              en_a,
  input  logic [N/BW-1:0]   we_a,
  input  logic [N-1:0]      w_data_a,
  output logic [N-1:0]      r_data_a,
  output logic              r_valid_a,
  input  logic [L-1:0]      addr_b,
  input  logic              en_b,
  input  logic [N/BW-1:0]   we_b,
  input  logic [N-1:0]      w_data_b,
  output logic [N-1:0]      r_data_b,
  output logic              r_valid_b,
  output logic              coll
);

  localparam int NB    = N / BW;
  localparam int MAX_M = 1 << L;

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t         state_q, state_d;
  logic [L-1:0]   cnt_q, cnt_d;
  logic [N-1:0]   mem [MAX_M];

  logic           act_a, act_b;
  logic [N-1:0]   old_a, old_b;
  logic [N-1:0]   rd_data_a_q, rd_data_a_d, rd_data_b_q, rd_data_b_d;
  logic           rd_valid_a_q, rd_valid_a_d, rd_valid_b_q, rd_valid_b_d;
  logic           coll_q, coll_d;

  function automatic logic [N-1:0] merge(input logic [N-1:0] old_w, input logic [N-1:0] new_w,
                                         input logic [NB-1:0] we);
    merge = old_w;
    for (int k = 0; k < NB; k++)
      if (we[k]) merge[k*BW +: BW] = new_w[k*BW +: BW];
  endfunction

  // Returns {valid, data} for one port's first read stage.
  function automatic logic [N:0] port_read(input logic act, input logic [NB-1:0] we,
                                           input logic [N-1:0] old_w, input logic [N-1:0] new_w,
                                           input logic [N-1:0] held);
    port_read = {1'b0, held};
    if (act) begin
      if (we == '0)         port_read = {1'b1, old_w};
      else if (RDW_MODE == 0) port_read = {1'b1, merge(old_w, new_w, we)};
      else if (RDW_MODE == 1) port_read = {1'b1, old_w};
    end
  endfunction

  assign init_busy = (state_q == S_CLEAR);
  assign act_a     = (state_q == S_READY) && en_a;
  assign act_b     = (state_q == S_READY) && en_b;
  assign old_a     = mem[addr_a];
  assign old_b     = mem[addr_b];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == S_CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == '1) state_d = S_READY;
    end
    {rd_valid_a_d, rd_data_a_d} = port_read(act_a, we_a, old_a, w_data_a, rd_data_a_q);
    {rd_valid_b_d, rd_data_b_d} = port_read(act_b, we_b, old_b, w_data_b, rd_data_b_q);
    coll_d = act_a && act_b && (addr_a == addr_b) && ((we_a != '0) || (we_b != '0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= (INIT_EN != 0) ? S_CLEAR : S_READY;
      cnt_q        <= '0;
      rd_data_a_q  <= '0;
      rd_data_b_q  <= '0;
      rd_valid_a_q <= 1'b0;
      rd_valid_b_q <= 1'b0;
      coll_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rd_data_a_q  <= rd_data_a_d;
      rd_data_b_q  <= rd_data_b_d;
      rd_valid_a_q <= rd_valid_a_d;
      rd_valid_b_q <= rd_valid_b_d;
      coll_q       <= coll_d;
    end
  end

  // Port A owns any lane both ports enable on the same address; B fills the rest.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (init_busy) begin
        mem[cnt_q] <= INIT_VAL;
      end else begin
        for (int k = 0; k < NB; k++) begin
          if (act_b && we_b[k] && !(act_a && we_a[k] && (addr_a == addr_b)))
            mem[addr_b][k*BW +: BW] <= w_data_b[k*BW +: BW];
          if (act_a && we_a[k])
            mem[addr_a][k*BW +: BW] <= w_data_a[k*BW +: BW];
        end
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [N-1:0] out_data_a_q, out_data_a_d, out_data_b_q, out_data_b_d;
    logic         out_valid_a_q, out_valid_b_q, out_coll_q;

    always_comb begin
      out_data_a_d = rd_valid_a_q ? rd_data_a_q : out_data_a_q;
      out_data_b_d = rd_valid_b_q ? rd_data_b_q : out_data_b_q;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        out_data_a_q  <= '0;
        out_data_b_q  <= '0;
        out_valid_a_q <= 1'b0;
        out_valid_b_q <= 1'b0;
        out_coll_q    <= 1'b0;
      end else begin
        out_data_a_q  <= out_data_a_d;
        out_data_b_q  <= out_data_b_d;
        out_valid_a_q <= rd_valid_a_q;
        out_valid_b_q <= rd_valid_b_q;
        out_coll_q    <= coll_q;
      end
    end

    assign r_data_a  = out_data_a_q;
    assign r_data_b  = out_data_b_q;
    assign r_valid_a = out_valid_a_q;
    assign r_valid_b = out_valid_b_q;
    assign coll      = out_coll_q;
  end else begin : g_direct
    assign r_data_a  = rd_data_a_q;
    assign r_data_b  = rd_data_b_q;
    assign r_valid_a = rd_valid_a_q;
    assign r_valid_b = rd_valid_b_q;
    assign coll      = coll_q;
  end

endmodule

// File: tb/tb_mem_2port_be.sv
// Randomised self-checking bench for mem_2port_be: a WRITE_FIRST single-stage instance plus
// three OUT_REG instances (one per read-during-write mode), checked against an array model.
module tb_mem_2port_be;

  localparam int N = 16;
  localparam int L = 4;
  localparam int DEPTH = 16;
  localparam logic [15:0] CLR = 16'hA5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        init_busy, coll;
  logic [3:0]  addr_a = '0, addr_b = '0;
  logic        en_a = 1'b0, en_b = 1'b0;
  logic [1:0]  we_a = '0, we_b = '0;
  logic [15:0] w_data_a = '0, w_data_b = '0;
  logic [15:0] r_data_a, r_data_b;
  logic        r_valid_a, r_valid_b;

  logic [3:0]  m_addr = '0;
  logic        m_en = 1'b0;
  logic [1:0]  m_we = '0;
  logic [15:0] m_wdata = '0;
  logic [15:0] m_rdata [3];
  logic [15:0] m_rdata_b [3];
  logic        m_rvalid [3];
  logic        m_rvalid_b [3];
  logic        m_busy [3];
  logic        m_coll [3];

  logic [15:0] ref_mem [DEPTH];
  logic [15:0] exp_da, exp_db;
  logic        exp_va, exp_vb, exp_coll;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  mem_2port_be #(.N(N), .L(L), .BW(8), .RDW_MODE(0), .OUT_REG(0), .INIT_EN(1),
                 .INIT_VAL(CLR)) dut (
    .clk(clk), .rst(rst), .init_busy(init_busy),
    .addr_a(addr_a), .en_a(en_a), .we_a(we_a), .w_data_a(w_data_a),
    .r_data_a(r_data_a), .r_valid_a(r_valid_a),
    .addr_b(addr_b), .en_b(en_b), .we_b(we_b), .w_data_b(w_data_b),
    .r_data_b(r_data_b), .r_valid_b(r_valid_b), .coll(coll));

  for (genvar g = 0; g < 3; g++) begin : g_modes
    mem_2port_be #(.N(N), .L(L), .BW(8), .RDW_MODE(g), .OUT_REG(1), .INIT_EN(1),
                   .INIT_VAL(16'h0000)) u_m (
      .clk(clk), .rst(rst), .init_busy(m_busy[g]),
      .addr_a(m_addr), .en_a(m_en), .we_a(m_we), .w_data_a(m_wdata),
      .r_data_a(m_rdata[g]), .r_valid_a(m_rvalid[g]),
      .addr_b(4'd0), .en_b(1'b0), .we_b(2'b00), .w_data_b(16'h0000),
      .r_data_b(m_rdata_b[g]), .r_valid_b(m_rvalid_b[g]), .coll(m_coll[g]));
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] lane_merge(input logic [15:0] old_w, input logic [15:0] new_w,
                                             input logic [1:0] we);
    lane_merge = {we[1] ? new_w[15:8] : old_w[15:8], we[0] ? new_w[7:0] : old_w[7:0]};
  endfunction

  // One clock of traffic on the main instance; the model predicts outputs from the pre-write
  // contents, then commits B's lanes followed by A's so A prevails on shared lanes.
  task automatic drive(input logic ea, input logic [3:0] aa, input logic [1:0] wea, input logic [15:0] wda,
                       input logic eb, input logic [3:0] ab, input logic [1:0] web, input logic [15:0] wdb);
    logic [15:0] old_a, old_b;
    en_a = ea; addr_a = aa; we_a = wea; w_data_a = wda;
    en_b = eb; addr_b = ab; we_b = web; w_data_b = wdb;
    old_a = ref_mem[aa];
    old_b = ref_mem[ab];
    exp_va = ea;
    exp_vb = eb;
    if (ea) exp_da = (wea == 2'b00) ? old_a : lane_merge(old_a, wda, wea);
    if (eb) exp_db = (web == 2'b00) ? old_b : lane_merge(old_b, wdb, web);
    exp_coll = ea && eb && (aa == ab) && ((wea != 2'b00) || (web != 2'b00));
    if (eb) ref_mem[ab] = lane_merge(ref_mem[ab], wdb, web);
    if (ea) ref_mem[aa] = lane_merge(ref_mem[aa], wda, wea);
    cycle();
  endtask

  task automatic mdrive(input logic e, input logic [3:0] a, input logic [1:0] we, input logic [15:0] d);
    m_en = e; m_addr = a; m_we = we; m_wdata = d;
    cycle();
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    n_vec++;
    if ({init_busy, r_valid_a, r_valid_b, coll} !== 4'b1000) begin
      n_err++;
      $display("[TB] FAIL reset_flags got busy/va/vb/coll=%b required 1000", {init_busy, r_valid_a, r_valid_b, coll});
    end
    n_vec++;
    if (r_data_a !== 16'h0 || r_data_b !== 16'h0) begin
      n_err++;
      $display("[TB] FAIL reset_data got %h/%h required 0000/0000", r_data_a, r_data_b);
    end
    n = 0;
    while (init_busy === 1'b1 && n < 40) begin
      n++;
      cycle();
    end
    n_vec++;
    if (n != DEPTH) begin
      n_err++;
      $display("[TB] FAIL sweep_len got %0d busy cycles required %0d", n, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = CLR;
    exp_da = 16'h0;
    exp_db = 16'h0;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 4'(i), 2'b00, 16'h0, 1'b1, 4'(DEPTH-1-i), 2'b00, 16'h0);
      n_vec++;
      if (r_data_a !== CLR || r_valid_a !== 1'b1) begin
        n_err++;
        $display("[TB] FAIL clear_read addr %0d got %h/%b required %h/1", i, r_data_a, r_valid_a, CLR);
      end
    end
  endtask

  task automatic test_lane_write();
    drive(1'b1, 4'd3, 2'b11, 16'hFFFF, 1'b0, 4'd0, 2'b00, 16'h0);
    drive(1'b1, 4'd3, 2'b01, 16'h1234, 1'b0, 4'd0, 2'b00, 16'h0);
    n_vec++;
    if (r_data_a !== 16'hFF34 || r_valid_a !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL lane_write_first got %h/%b required ff34/1", r_data_a, r_valid_a);
    end
    drive(1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'd3, 2'b00, 16'h0);
    n_vec++;
    if (r_data_b !== 16'hFF34 || r_valid_b !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL lane_readback got %h/%b required ff34/1", r_data_b, r_valid_b);
    end
  endtask

  task automatic test_collision();
    drive(1'b1, 4'd5, 2'b10, 16'h1111, 1'b1, 4'd5, 2'b11, 16'h2222);
    n_vec++;
    if (coll !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL coll_both_write got %b required 1", coll);
    end
    drive(1'b1, 4'd5, 2'b00, 16'h0, 1'b1, 4'd5, 2'b00, 16'h0);
    n_vec++;
    if (r_data_a !== 16'h1122 || r_data_b !== 16'h1122) begin
      n_err++;
      $display("[TB] FAIL both_write_merge got %h/%h required 1122/1122", r_data_a, r_data_b);
    end
    n_vec++;
    if (coll !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL coll_two_reads got %b required 0", coll);
    end
  endtask

  task automatic test_cross_read();
    logic [15:0] held_a;
    drive(1'b1, 4'd7, 2'b11, 16'h0000, 1'b0, 4'd0, 2'b00, 16'h0);
    held_a = r_data_a;
    drive(1'b1, 4'd7, 2'b11, 16'hBEEF, 1'b1, 4'd7, 2'b00, 16'h0);
    n_vec++;
    if (r_data_b !== 16'h0000 || r_valid_b !== 1'b1 || coll !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL cross_old_read got %h/%b coll %b required 0000/1 coll 1", r_data_b, r_valid_b, coll);
    end
    held_a = r_data_a;
    drive(1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'd7, 2'b00, 16'h0);
    n_vec++;
    if (r_data_b !== 16'hBEEF || coll !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL cross_new_read got %h coll %b required beef coll 0", r_data_b, coll);
    end
    n_vec++;
    if (r_valid_a !== 1'b0 || r_data_a !== held_a) begin
      n_err++;
      $display("[TB] FAIL idle_hold got %h/%b required %h/0", r_data_a, r_valid_a, held_a);
    end
  endtask

  task automatic test_random();
    logic ea, eb;
    logic [3:0] aa, ab;
    logic [1:0] wea, web;
    for (int t = 0; t < 300; t++) begin
      ea  = 1'($urandom_range(0, 1));
      eb  = 1'($urandom_range(0, 1));
      aa  = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      ab  = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      wea = ($urandom_range(0, 1) != 0) ? 2'b00 : 2'($urandom_range(1, 3));
      web = ($urandom_range(0, 1) != 0) ? 2'b00 : 2'($urandom_range(1, 3));
      if (ea && eb && aa == ab && wea != 2'b00 && web != 2'b00) web = 2'b00;
      drive(ea, aa, wea, 16'($urandom), eb, ab, web, 16'($urandom));
      n_vec++;
      if (r_valid_a !== exp_va || r_data_a !== exp_da) begin
        n_err++;
        $display("[TB] FAIL rand_a t=%0d got %h/%b required %h/%b", t, r_data_a, r_valid_a, exp_da, exp_va);
      end
      n_vec++;
      if (r_valid_b !== exp_vb || r_data_b !== exp_db) begin
        n_err++;
        $display("[TB] FAIL rand_b t=%0d got %h/%b required %h/%b", t, r_data_b, r_valid_b, exp_db, exp_vb);
      end
      n_vec++;
      if (coll !== exp_coll) begin
        n_err++;
        $display("[TB] FAIL rand_coll t=%0d got %b required %b", t, coll, exp_coll);
      end
    end
  endtask

  task automatic test_rdw_modes();
    logic [15:0] want_d [3];
    logic        want_v [3];
    want_d[0] = 16'h00AA; want_d[1] = 16'h0055; want_d[2] = 16'h0055;
    want_v[0] = 1'b1;     want_v[1] = 1'b1;     want_v[2] = 1'b0;
    mdrive(1'b1, 4'd2, 2'b11, 16'h0055);
    mdrive(1'b0, 4'd0, 2'b00, 16'h0);
    mdrive(1'b0, 4'd0, 2'b00, 16'h0);
    mdrive(1'b1, 4'd2, 2'b00, 16'h0);
    for (int g = 0; g < 3; g++) begin
      n_vec++;
      if (m_rvalid[g] !== 1'b0) begin
        n_err++;
        $display("[TB] FAIL latency2_early mode %0d got valid %b required 0", g, m_rvalid[g]);
      end
    end
    mdrive(1'b0, 4'd0, 2'b00, 16'h0);
    for (int g = 0; g < 3; g++) begin
      n_vec++;
      if (m_rdata[g] !== 16'h0055 || m_rvalid[g] !== 1'b1) begin
        n_err++;
        $display("[TB] FAIL latency2_read mode %0d got %h/%b required 0055/1", g, m_rdata[g], m_rvalid[g]);
      end
    end
    mdrive(1'b1, 4'd2, 2'b11, 16'h00AA);
    mdrive(1'b0, 4'd0, 2'b00, 16'h0);
    for (int g = 0; g < 3; g++) begin
      n_vec++;
      if (m_rdata[g] !== want_d[g] || m_rvalid[g] !== want_v[g]) begin
        n_err++;
        $display("[TB] FAIL rdw mode %0d got %h/%b required %h/%b", g, m_rdata[g], m_rvalid[g], want_d[g], want_v[g]);
      end
    end
    mdrive(1'b1, 4'd2, 2'b00, 16'h0);
    mdrive(1'b0, 4'd0, 2'b00, 16'h0);
    for (int g = 0; g < 3; g++) begin
      n_vec++;
      if (m_rdata[g] !== 16'h00AA || m_rvalid[g] !== 1'b1) begin
        n_err++;
        $display("[TB] FAIL rdw_stored mode %0d got %h/%b required 00aa/1", g, m_rdata[g], m_rvalid[g]);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    rst = 1'b1;
    drive(1'b0, 4'd0, 2'b00, 16'h0, 1'b0, 4'd0, 2'b00, 16'h0);
    rst = 1'b0;
    en_a = 1'b1; addr_a = 4'd12; we_a = 2'b11; w_data_a = 16'h1234;
    en_b = 1'b1; addr_b = 4'd0;  we_b = 2'b00; w_data_b = 16'h0;
    for (int j = 0; j < 9; j++) cycle();
    n_vec++;
    if (init_busy !== 1'b1 || r_valid_a !== 1'b0 || r_valid_b !== 1'b0 || r_data_a !== 16'h0) begin
      n_err++;
      $display("[TB] FAIL sweep_ignore got busy %b va %b vb %b da %h required 1 0 0 0000",
               init_busy, r_valid_a, r_valid_b, r_data_a);
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    n = 0;
    while (init_busy === 1'b1 && n < 40) begin
      n++;
      cycle();
      n_vec++;
      if (r_valid_a !== 1'b0 || r_valid_b !== 1'b0) begin
        n_err++;
        $display("[TB] FAIL sweep_valid got %b/%b required 0/0", r_valid_a, r_valid_b);
      end
    end
    n_vec++;
    if (n != DEPTH) begin
      n_err++;
      $display("[TB] FAIL restart_len got %0d busy cycles required %0d", n, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = CLR;
    exp_da = 16'h0;
    exp_db = 16'h0;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'(i), 2'b00, 16'h0);
      n_vec++;
      if (r_data_b !== CLR) begin
        n_err++;
        $display("[TB] FAIL reclear addr %0d got %h required %h", i, r_data_b, CLR);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lane_write();
    test_collision();
    test_cross_read();
    test_random();
    test_rdw_modes();
    test_reset_mid_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
